booth_seq_mult_ctrl: RTL and testbench
======================================

Name: booth_seq_mult_ctrl

Overview:
- Iterative radix-2 Booth signed multiplier controller.
- Accepts one operand pair over a valid/ready handshake and performs one Booth add/subtract-and-shift step per clock for WIDTH steps, reusing a single step datapath.
- Presents the 2*WIDTH-bit product over a valid/ready output handshake.
- Area-reduced sequential alternative to the unrolled four-stage combinational Booth chain; serves the same M×Q→Z function for blocks that can tolerate latency.

Parameters:
- WIDTH, 4, operand width in bits (two's complement); product is 2*WIDTH bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the internal step counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair M/Q valid.
- in_ready  output  1  controller can accept operands (high only in IDLE).
- M  input  WIDTH  multiplicand, signed.
- Q  input  WIDTH  multiplier, signed.
- out_valid  output  1  product Z valid.
- out_ready  input  1  consumer accepts Z.
- Z  output  2*WIDTH  signed product M*Q.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock domain (clk). rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, Z=0.
  - Internal A=0, Qreg=0, Mreg=0, cnt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On rising edge with in_valid=1:
    - Mreg ← M sign-extended to WIDTH+1 bits.
    - A ← 0 (WIDTH+1 bits).
    - Qreg ← {Q,1'b0} (WIDTH+1 bits).
    - cnt ← WIDTH.
    - state ← RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0. One step per edge, based on Qreg[1:0]:
    - 2'b01: A' = A+Mreg.
    - 2'b10: A' = A−Mreg.
    - 2'b00 / 2'b11: A' = A.
  - Then arithmetic right shift of {A',Qreg} by 1: the MSB of A' is replicated and the LSB of A' enters Qreg[WIDTH].
  - Arithmetic is modulo 2^(WIDTH+1). The extra guard bit makes M = −2^(WIDTH−1) correct.
  - cnt decrements by 1 each step. On the edge where cnt==1 (the last step), state ← DONE and Z ← {A'[WIDTH−1:0] after shift, Qreg[WIDTH:1] after shift}.
- DONE:
  - out_valid=1, Z held stable.
  - On edge with out_ready=1: out_valid ← 0, state ← IDLE.
  - out_ready=0: hold DONE indefinitely, with Z and out_valid unchanged.
- Latency: accept edge at cycle 0. out_valid is visible after edge WIDTH (WIDTH cycles later).
- Throughput: one product per WIDTH+2 cycles minimum. A new operand cannot be accepted in the same cycle as the output handshake; in_ready rises the cycle after it.
- in_valid/M/Q are ignored outside IDLE. Operands are captured only at the accept edge; later changes have no effect.
- Z keeps its last product value in IDLE. Z is meaningful only while out_valid=1.
- Asynchronous rst at any point (mid-RUN, or in DONE with out_valid high) forces the reset values immediately. The in-flight product is discarded and no out_valid is produced for it.
- out_ready while not in DONE is ignored.
- Z must equal the exact signed product for every operand pair, including (−2^(WIDTH−1))².

Test Plan:
- WIDTH=4, M=3, Q=5, out_ready=1 → out_valid high exactly 4 cycles after the accept edge, Z=8'h0F; in_ready low for those 4 cycles plus the DONE cycle.
- M=−3 (4'hD), Q=5 → Z=8'hF1 (−15); then M=7, Q=−8 (4'h8) → Z=8'hC8 (−56).
- M=−8, Q=−8 → Z=8'h40 (+64), which exercises the guard bit; M=0, Q=−1 → Z=8'h00.
- Backpressure: out_ready=0 for 10 cycles after out_valid. Z and out_valid stay stable and in_ready stays 0. Raising out_ready completes the transfer, and in_ready=1 on the next cycle.
- Change M/Q and toggle in_valid during RUN → the result is unaffected (M=2, Q=3 gives Z=8'h06).
- Assert rst 2 cycles into RUN → out_valid=0, in_ready=1, busy=0 immediately. The next operation (M=−1, Q=−1) gives Z=8'h01.
- Exhaustive sweep of all 256 signed pairs against a reference model, with randomized out_ready → zero mismatches.

Source files
------------

// File: rtl/booth_seq_mult_ctrl.sv
// Iterative radix-2 Booth signed multiplier controller.
// Accepts one operand pair per valid/ready handshake and runs one Booth
// add/subtract-and-shift step per clock for WIDTH clocks through a single
// step datapath. The 2*WIDTH-bit product is then held until the consumer
// takes it.
module booth_seq_mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   M,
  input  logic signed [WIDTH-1:0]   Q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] Z,
  output logic                      busy
);

  // The accumulator and multiplicand carry one guard bit, so that
  // M = -2^(WIDTH-1) can be negated without overflow.
  localparam int AW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [AW-1:0]   a_reg;
  logic        [AW-1:0]   q_reg;
  logic signed [AW-1:0]   m_reg;
  logic        [CNT_W-1:0] cnt;
  logic signed [2*WIDTH-1:0] z_reg;
  logic signed [2*AW-1:0] step;
  logic                   last_step;

  // One Booth step. The pair {A', Qreg} is shifted right arithmetically.
  // The result is returned as {A_next, Qreg_next}.
  function automatic logic signed [2*AW-1:0] booth_step(
    input logic signed [AW-1:0] a,
    input logic        [AW-1:0] q,
    input logic signed [AW-1:0] m
  );
    logic signed [AW-1:0]   a_n;
    logic signed [2*AW-1:0] pair;
    case (q[1:0])
      2'b01:   a_n = a + m;
      2'b10:   a_n = a - m;
      default: a_n = a;
    endcase
    pair = {a_n, q};
    return pair >>> 1;
  endfunction

  assign step      = booth_step(a_reg, q_reg, m_reg);
  assign last_step = (cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count steps in RUN, hand off in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step datapath: load operands on accept, iterate in RUN, and latch the
  // product on the last step. The product is kept afterwards so that Z
  // stays stable through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      q_reg <= '0;
      m_reg <= '0;
      cnt   <= '0;
      z_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg <= {M[WIDTH-1], M};
            a_reg <= '0;
            q_reg <= {Q, 1'b0};
            cnt   <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          a_reg <= step[2*AW-1:AW];
          q_reg <= step[AW-1:0];
          cnt   <= cnt - CNT_W'(1);
          // {A_next[WIDTH-1:0], Qreg_next[WIDTH:1]} is the contiguous slice [2*WIDTH:1]
          if (last_step) z_reg <= step[2*WIDTH:1];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign Z         = z_reg;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Self-checking bench for booth_seq_mult_ctrl at WIDTH=4.
// Expected products come from plain integer multiplication.
module tb_booth_seq_mult_ctrl;

  localparam int W = 4;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   M;
  logic signed [W-1:0]   Q;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*W-1:0] Z;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  booth_seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M         (M),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: exact signed product, truncated to 2*W bits
  function automatic logic [2*W-1:0] ref_prod(input logic signed [W-1:0] m,
                                              input logic signed [W-1:0] q);
    int p;
    p = int'(m) * int'(q);
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one transaction end to end and return the product seen at the handshake
  task automatic do_op(input logic signed [W-1:0] m, input logic signed [W-1:0] q,
                       input bit rand_rdy, output logic [2*W-1:0] z,
                       output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    z   = '0;
    n   = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin to = 1'b1; return; end
    if (rand_rdy) repeat ($urandom_range(0, 2)) tick();
    M = m; Q = q; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    M = W'($urandom);
    Q = W'($urandom);
    while (!out_valid && lat < 50) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      lat++;
    end
    if (!out_valid) begin to = 1'b1; out_ready = 1'b0; return; end
    n = 0;
    while (out_valid && n < 50) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      z = Z;
      tick();
      n++;
    end
    if (out_valid) to = 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; M = '0; Q = '0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (Z !== 8'h00) begin errors++; $display("FAIL reset_z: got %h expected 00", Z); end
    // in_valid must not be acted on while reset is held
    in_valid = 1'b1; M = 4'd3; Q = 4'd3;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy: got %b expected 0", busy); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int k;
    int bad_ready;
    k = 0; bad_ready = 0;
    M = 4'd3; Q = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && k < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
      tick();
      k++;
    end
    if (in_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
    checks++; if (k !== W) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", k, W); end
    checks++; if (Z !== 8'h0F) begin errors++; $display("FAIL basic_z: got %h expected 0f", Z); end
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL basic_in_ready_low: got %0d bad cycles expected 0", bad_ready); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake: got out_valid %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", in_ready); end
    checks++; if (Z !== 8'h0F) begin errors++; $display("FAIL basic_z_held_idle: got %h expected 0f", Z); end
  endtask

  task automatic test_signed();
    logic [W-1:0]   tm [4] = '{4'hD, 4'h7, 4'h8, 4'h0};
    logic [W-1:0]   tq [4] = '{4'h5, 4'h8, 4'h8, 4'hF};
    logic [2*W-1:0] tz [4] = '{8'hF1, 8'hC8, 8'h40, 8'h00};
    logic [2*W-1:0] z;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      do_op(tm[i], tq[i], 1'b0, z, lat, to);
      checks++;
      if (to || z !== tz[i]) begin
        errors++;
        $display("FAIL signed_%0d: M=%h Q=%h got %h (timeout %0b) expected %h", i, tm[i], tq[i], z, to, tz[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [W-1:0] m;
    logic signed [W-1:0] q;
    logic [2*W-1:0] exp_z;
    int k;
    int unstable;
    m = W'($urandom); q = W'($urandom);
    exp_z = ref_prod(m, q);
    k = 0; unstable = 0;
    M = m; Q = q; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    while (!out_valid && k < 20) begin tick(); k++; end
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Z !== exp_z) unstable++;
      tick();
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", unstable); end
    checks++; if (Z !== exp_z) begin errors++; $display("FAIL backpressure_z: got %h expected %h", Z, exp_z); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release: got valid %b ready %b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_input_ignored();
    int k;
    k = 0;
    M = 4'd2; Q = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    while (!out_valid && k < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      M = W'($urandom);
      Q = W'($urandom);
      tick();
      k++;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || Z !== 8'h06) begin errors++; $display("FAIL input_ignored: got %h valid %b expected 06 valid 1", Z, out_valid); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] z;
    int lat;
    bit to;
    int spurious;
    spurious = 0;
    M = 4'd5; Q = 4'd6; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_run: got valid %b ready %b busy %b expected 0 1 0", out_valid, in_ready, busy); end
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid !== 1'b0) spurious++; end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL rst_discard: got %0d out_valid cycles expected 0", spurious); end
    do_op(4'hF, 4'hF, 1'b0, z, lat, to);
    checks++; if (to || z !== 8'h01) begin errors++; $display("FAIL rst_next_op: got %h (timeout %0b) expected 01", z, to); end
    // Reset while the product is waiting in DONE
    M = 4'd7; Q = 4'd7; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Z !== 8'h00) begin errors++; $display("FAIL rst_in_done: got valid %b ready %b z %h expected 0 1 00", out_valid, in_ready, Z); end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_exhaustive();
    int order [256];
    int j;
    int tmp;
    int bad;
    logic signed [W-1:0] m;
    logic signed [W-1:0] q;
    logic [2*W-1:0] z;
    logic [2*W-1:0] exp_z;
    int lat;
    bit to;
    bad = 0;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      tmp = order[i];
      m = tmp[7:4];
      q = tmp[3:0];
      exp_z = ref_prod(m, q);
      do_op(m, q, 1'b1, z, lat, to);
      checks++;
      if (to || z !== exp_z || lat !== W) begin
        errors++;
        $display("FAIL sweep M=%h Q=%h: got %h lat %0d (timeout %0b) expected %h lat %0d", m, q, z, lat, to, exp_z, W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_input_ignored();
    test_async_reset();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
